filter_pipeline: RTL and testbench

- Five-stage in-order pipeline (Fetch, Decode, Execute, Memory, Writeback) for the image-filter GPU.
- Combines datapath, instruction decode and hazard logic in one block.
- Operates on 3-lane vectors of 18-bit pixels in a 16-entry register file, using an external instruction memory and a 3-port data memory.
- A 2-bit kernel input selects the coefficient for the filter ALU operation.

---
 rtl/filter_pipeline.sv | 244 ++++++++++++++++++++++++
 tb/tb_filter_pipeline.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_pipeline.sv
// filter_pipeline: five-stage, three-lane, 18-bit vector pipeline for the image-filter GPU.
// Latency: fetch t, memory port t+3, register write end of t+4; a load-use pair costs one stall.
module filter_pipeline (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       kernel,
    input  logic [27:0]      Instr,
    input  logic [2:0][17:0] ReadData,
    output logic [31:0]      PC,
    output logic             MemWriteM,
    output logic [2:0][17:0] writeData,
    output logic [18:0]      A1,
    output logic [18:0]      A2,
    output logic [18:0]      A3
);
    localparam logic [2:0] CLS_ALUR = 3'b000;
    localparam logic [2:0] CLS_ALUI = 3'b001;
    localparam logic [2:0] CLS_LDR  = 3'b010;
    localparam logic [2:0] CLS_STR  = 3'b011;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_LSR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_FLT = 3'b110;

    typedef logic [2:0][17:0] lanes_t;
    typedef logic [2:0][18:0] addrs_t;

    function automatic logic [17:0] alu_lane(input logic [2:0]  op,
                                             input logic [17:0] a,
                                             input logic [17:0] b,
                                             input logic [1:0]  k);
        logic [35:0] prod;
        logic [17:0] scaled;
        logic [17:0] res;
        prod = {18'd0, a} * {18'd0, b};
        case (k)
            2'b00:   scaled = a;
            2'b01:   scaled = {a[16:0], 1'b0};
            2'b10:   scaled = {a[15:0], 2'b00};
            default: scaled = 18'd0 - a;
        endcase
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_ORR:  res = a | b;
            OP_LSR:  res = (b[4:0] >= 5'd18) ? 18'd0 : (a >> b[4:0]);
            OP_MUL:  res = prod[17:0];
            OP_FLT:  res = scaled + b;
            default: res = b;
        endcase
        return res;
    endfunction

    // Fetch / Decode
    logic [31:0] r_pc;
    logic        r_d_vld;
    logic [27:0] r_d_instr;
    lanes_t      r_rf [16];

    logic [2:0]  w_d_cls;
    logic [2:0]  w_d_op;
    logic [3:0]  w_d_rd;
    logic [3:0]  w_d_rn;
    logic [3:0]  w_d_rs2;
    logic [13:0] w_d_imm;
    lanes_t      w_d_a;
    lanes_t      w_d_b;
    logic        w_stall;

    // Execute
    logic        r_e_vld;
    logic [2:0]  r_e_cls;
    logic [2:0]  r_e_op;
    logic [3:0]  r_e_rd;
    logic [3:0]  r_e_rn;
    logic [3:0]  r_e_rs2;
    logic [13:0] r_e_imm;
    lanes_t      r_e_a;
    lanes_t      r_e_b;
    lanes_t      w_e_a;
    lanes_t      w_e_b;
    lanes_t      w_e_opb;
    lanes_t      w_e_res;
    addrs_t      w_e_addr;
    logic        w_e_wr;

    // Memory / Writeback
    logic        r_m_vld;
    logic [2:0]  r_m_cls;
    logic [3:0]  r_m_rd;
    logic        r_m_wr;
    lanes_t      r_m_res;
    lanes_t      r_m_sdat;
    addrs_t      r_m_addr;
    lanes_t      w_m_fwd;
    logic        r_w_wr;
    logic [3:0]  r_w_rd;
    lanes_t      r_w_dat;

    assign w_d_cls = r_d_instr[27:25];
    assign w_d_op  = r_d_instr[24:22];
    assign w_d_rd  = r_d_instr[21:18];
    assign w_d_rn  = r_d_instr[17:14];
    assign w_d_imm = r_d_instr[13:0];
    // Stores read their data register through the second port in place of Rm.
    assign w_d_rs2 = (w_d_cls == CLS_STR) ? w_d_rd : r_d_instr[13:10];

    always_comb begin
        w_d_a = r_rf[w_d_rn];
        w_d_b = r_rf[w_d_rs2];
        if (r_w_wr && (r_w_rd == w_d_rn)) begin
            w_d_a = r_w_dat;
        end
        if (r_w_wr && (r_w_rd == w_d_rs2)) begin
            w_d_b = r_w_dat;
        end
    end

    assign w_stall = r_e_vld && (r_e_cls == CLS_LDR) &&
                     ((r_e_rd == w_d_rn) || (r_e_rd == w_d_rs2));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pc      <= '0;
            r_d_vld   <= 1'b0;
            r_d_instr <= '0;
        end else if (!w_stall) begin
            r_pc      <= r_pc + 32'd1;
            r_d_vld   <= 1'b1;
            r_d_instr <= Instr;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_e_vld <= 1'b0;
            r_e_cls <= '0;
            r_e_op  <= '0;
            r_e_rd  <= '0;
            r_e_rn  <= '0;
            r_e_rs2 <= '0;
            r_e_imm <= '0;
            r_e_a   <= '0;
            r_e_b   <= '0;
        end else begin
            r_e_vld <= r_d_vld && !w_stall;
            r_e_cls <= w_d_cls;
            r_e_op  <= w_d_op;
            r_e_rd  <= w_d_rd;
            r_e_rn  <= w_d_rn;
            r_e_rs2 <= w_d_rs2;
            r_e_imm <= w_d_imm;
            r_e_a   <= w_d_a;
            r_e_b   <= w_d_b;
        end
    end

    // A load in Memory forwards its read data; the interlock normally keeps that path idle.
    assign w_m_fwd = (r_m_cls == CLS_LDR) ? ReadData : r_m_res;

    always_comb begin
        w_e_a = r_e_a;
        w_e_b = r_e_b;
        if (r_w_wr && (r_w_rd == r_e_rn)) begin
            w_e_a = r_w_dat;
        end
        if (r_m_wr && (r_m_rd == r_e_rn)) begin
            w_e_a = w_m_fwd;
        end
        if (r_w_wr && (r_w_rd == r_e_rs2)) begin
            w_e_b = r_w_dat;
        end
        if (r_m_wr && (r_m_rd == r_e_rs2)) begin
            w_e_b = w_m_fwd;
        end
    end

    assign w_e_opb = (r_e_cls == CLS_ALUI) ? {3{4'd0, r_e_imm}} : w_e_b;
    assign w_e_wr  = r_e_vld && ((r_e_cls == CLS_ALUR) || (r_e_cls == CLS_ALUI) ||
                                 (r_e_cls == CLS_LDR));

    always_comb begin
        w_e_res  = '0;
        w_e_addr = '0;
        for (int i = 0; i < 3; i++) begin
            w_e_res[i]  = alu_lane(r_e_op, w_e_a[i], w_e_opb[i], kernel);
            w_e_addr[i] = {1'b0, w_e_a[i]} + {{5{r_e_imm[13]}}, r_e_imm};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_m_vld  <= 1'b0;
            r_m_cls  <= '0;
            r_m_rd   <= '0;
            r_m_wr   <= 1'b0;
            r_m_res  <= '0;
            r_m_sdat <= '0;
            r_m_addr <= '0;
        end else begin
            r_m_vld  <= r_e_vld;
            r_m_cls  <= r_e_cls;
            r_m_rd   <= r_e_rd;
            r_m_wr   <= w_e_wr;
            r_m_res  <= w_e_res;
            r_m_sdat <= w_e_b;
            r_m_addr <= w_e_addr;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_w_wr  <= 1'b0;
            r_w_rd  <= '0;
            r_w_dat <= '0;
        end else begin
            r_w_wr  <= r_m_wr;
            r_w_rd  <= r_m_rd;
            r_w_dat <= w_m_fwd;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) begin
                r_rf[i] <= '0;
            end
        end else if (r_w_wr) begin
            r_rf[r_w_rd] <= r_w_dat;
        end
    end

    assign PC        = r_pc;
    assign MemWriteM = r_m_vld && (r_m_cls == CLS_STR);
    assign writeData = r_m_sdat;
    assign A1        = r_m_addr[0];
    assign A2        = r_m_addr[1];
    assign A3        = r_m_addr[2];
endmodule

// File: tb/tb_filter_pipeline.sv
// Bench for filter_pipeline: directed vector table, hand-written reset sequences,
// and random programs checked against an instruction-level reference interpreter.
module tb_filter_pipeline;
    logic             CLK;
    logic             RST;
    logic [1:0]       kernel;
    logic [27:0]      Instr;
    logic [2:0][17:0] ReadData;
    logic [31:0]      PC;
    logic             MemWriteM;
    logic [2:0][17:0] writeData;
    logic [18:0]      A1;
    logic [18:0]      A2;
    logic [18:0]      A3;

    filter_pipeline dut (
        .CLK(CLK), .RST(RST), .kernel(kernel), .Instr(Instr), .ReadData(ReadData),
        .PC(PC), .MemWriteM(MemWriteM), .writeData(writeData), .A1(A1), .A2(A2), .A3(A3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam logic [27:0] NOP = 28'h8000000;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_FLT = 3'd6;

    int n_cmp = 0;
    int n_bad = 0;

    logic [27:0]      imem [256];
    logic             ovr_en;
    logic [2:0][17:0] ovr_val;

    function automatic logic [17:0] mem_fn(input int lane, input logic [18:0] a);
        logic [31:0] h;
        h = (32'(a) * 32'd40503) ^ (32'(lane) * 32'h1555) ^ 32'h2a5;
        return h[17:0];
    endfunction

    assign Instr       = imem[PC[7:0]];
    assign ReadData[0] = ovr_en ? ovr_val[0] : mem_fn(0, A1);
    assign ReadData[1] = ovr_en ? ovr_val[1] : mem_fn(1, A2);
    assign ReadData[2] = ovr_en ? ovr_val[2] : mem_fn(2, A3);

    function automatic logic [27:0] i_reg(input logic [2:0] op, input logic [3:0] rd,
                                          input logic [3:0] rn, input logic [3:0] rm);
        return {3'b000, op, rd, rn, rm, 10'd0};
    endfunction
    function automatic logic [27:0] i_imm(input logic [2:0] op, input logic [3:0] rd,
                                          input logic [3:0] rn, input logic [13:0] imm);
        return {3'b001, op, rd, rn, imm};
    endfunction
    function automatic logic [27:0] i_ldr(input logic [3:0] rd, input logic [3:0] rn,
                                          input logic [13:0] imm);
        return {3'b010, 3'b000, rd, rn, imm};
    endfunction
    function automatic logic [27:0] i_str(input logic [3:0] rd, input logic [3:0] rn,
                                          input logic [13:0] imm);
        return {3'b011, 3'b000, rd, rn, imm};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    // Reference lane arithmetic from the instruction-set rules, using wide integers.
    function automatic logic [17:0] ref_alu(input logic [2:0] op, input logic [17:0] a,
                                            input logic [17:0] b, input logic [1:0] k);
        longint x, y, r, c;
        x = longint'(a);
        y = longint'(b);
        c = (k == 2'd0) ? 1 : (k == 2'd1) ? 2 : (k == 2'd2) ? 4 : -1;
        case (op)
            3'd0:    r = x + y;
            3'd1:    r = x - y;
            3'd2:    r = x & y;
            3'd3:    r = x | y;
            3'd4:    r = (b[4:0] >= 5'd18) ? 0 : (x >> b[4:0]);
            3'd5:    r = x * y;
            3'd6:    r = x * c + y;
            default: r = y;
        endcase
        return r[17:0];
    endfunction

    typedef struct {
        string            name;
        logic [7:0][27:0] prog;
        logic [1:0]       kern;
        logic             ovr;
        logic [2:0][17:0] ovr_v;
        logic [18:0]      exp_addr;
        logic [2:0][17:0] exp_data;
        int               exp_stalls;
    } tv_t;

    function automatic logic [7:0][27:0] prog4(input logic [27:0] a, input logic [27:0] b,
                                               input logic [27:0] c, input logic [27:0] d);
        logic [7:0][27:0] p;
        for (int j = 0; j < 8; j++) p[j] = NOP;
        p[0] = a; p[1] = b; p[2] = c; p[3] = d;
        return p;
    endfunction

    function automatic tv_t mk(input string nm, input logic [7:0][27:0] p, input logic [1:0] k,
                               input logic ov, input logic [2:0][17:0] ovv,
                               input logic [18:0] ea, input logic [2:0][17:0] ed, input int es);
        tv_t t;
        t.name = nm; t.prog = p; t.kern = k; t.ovr = ov; t.ovr_v = ovv;
        t.exp_addr = ea; t.exp_data = ed; t.exp_stalls = es;
        return t;
    endfunction

    task automatic run_vec(input tv_t v);
        logic [31:0] prev;
        int          stalls;
        bit          seen;
        for (int j = 0; j < 256; j++) imem[j] = NOP;
        for (int j = 0; j < 8; j++) imem[j] = v.prog[j];
        kernel  = v.kern;
        ovr_en  = v.ovr;
        ovr_val = v.ovr_v;
        do_reset();
        prev   = PC;
        stalls = 0;
        seen   = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (PC == prev) stalls++;
            prev = PC;
            if (MemWriteM && !seen) begin
                seen = 1'b1;
                check({v.name, "_addr"}, {A1, A2, A3}, {3{v.exp_addr}});
                check({v.name, "_data"}, writeData, v.exp_data);
            end
        end
        check({v.name, "_store_seen"}, seen, 1);
        check({v.name, "_stalls"}, stalls, v.exp_stalls);
        ovr_en = 1'b0;
    endtask

    function automatic logic [27:0] rand_instr();
        int          r;
        logic [3:0]  rd, rn, rm;
        logic [2:0]  op;
        logic [13:0] imm;
        r   = $urandom_range(0, 99);
        rd  = 4'($urandom_range(0, 7));
        rn  = 4'($urandom_range(0, 7));
        rm  = 4'($urandom_range(0, 7));
        op  = 3'($urandom_range(0, 7));
        imm = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 16383))
                                          : 14'($urandom_range(0, 40));
        if (r < 30) return i_reg(op, rd, rn, rm);
        if (r < 55) return i_imm(op, rd, rn, imm);
        if (r < 75) return i_ldr(rd, rn, imm);
        if (r < 88) return i_str(rd, rn, imm);
        return {3'b100 | 3'($urandom_range(0, 3)), 25'($urandom)};
    endfunction

    task automatic run_random(input int idx);
        logic [27:0]      prog [64];
        logic [17:0]      mr [16][3];
        logic [110:0]     expq [$];
        logic [27:0]      ins, nx;
        logic [2:0]       cls, op;
        logic [3:0]       rd, rn, rm, p2;
        logic [13:0]      imm;
        logic [17:0]      b;
        logic [18:0]      ad [3];
        logic [2:0][17:0] sd;
        logic [31:0]      t, prev;
        logic [1:0]       k;
        int               off, exp_st, stalls, n_st, n_exp;
        for (int j = 0; j < 40; j++) prog[j] = rand_instr();
        for (int j = 0; j < 8; j++) prog[40 + j] = i_str(4'(j), 4'd0, 14'(j));
        for (int j = 48; j < 64; j++) prog[j] = NOP;
        k = 2'($urandom_range(0, 3));
        for (int r = 0; r < 16; r++) for (int l = 0; l < 3; l++) mr[r][l] = '0;
        exp_st = 0;
        for (int j = 0; j < 48; j++) begin
            ins = prog[j];
            cls = ins[27:25]; op = ins[24:22]; rd = ins[21:18];
            rn  = ins[17:14]; rm = ins[13:10]; imm = ins[13:0];
            off = imm[13] ? int'(imm) - 16384 : int'(imm);
            for (int l = 0; l < 3; l++) begin
                t     = 32'(mr[rn][l]) + 32'(off);
                ad[l] = t[18:0];
                sd[l] = mr[rd][l];
            end
            case (cls)
                3'b000, 3'b001: for (int l = 0; l < 3; l++) begin
                    b = (cls == 3'b000) ? mr[rm][l] : {4'd0, imm};
                    mr[rd][l] = ref_alu(op, mr[rn][l], b, k);
                end
                3'b010: for (int l = 0; l < 3; l++) mr[rd][l] = mem_fn(l, ad[l]);
                3'b011: expq.push_back({ad[0], ad[1], ad[2], sd});
                default: ;
            endcase
            if (cls == 3'b010) begin
                nx = prog[j + 1];
                p2 = (nx[27:25] == 3'b011) ? nx[21:18] : nx[13:10];
                if ((rd == nx[17:14]) || (rd == p2)) exp_st++;
            end
        end
        n_exp = expq.size();
        for (int j = 0; j < 256; j++) imem[j] = NOP;
        for (int j = 0; j < 64; j++) imem[j] = prog[j];
        kernel = k;
        ovr_en = 1'b0;
        do_reset();
        prev   = PC;
        stalls = 0;
        n_st   = 0;
        for (int c = 0; c < 106; c++) begin
            @(negedge CLK);
            if (PC == prev) stalls++;
            prev = PC;
            if (MemWriteM) begin
                n_st++;
                if (expq.size() != 0) check($sformatf("rand%0d_store", idx),
                                            {A1, A2, A3, writeData}, expq.pop_front());
            end
        end
        check($sformatf("rand%0d_store_count", idx), n_st, n_exp);
        check($sformatf("rand%0d_stalls", idx), stalls, exp_st);
    endtask

    tv_t vecs [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        for (int j = 0; j < 256; j++) imem[j] = NOP;
        kernel  = 2'd0;
        ovr_en  = 1'b0;
        ovr_val = '0;
        RST     = 1'b1;
        #1 RST  = 1'b0;

        // Reset state and fetch restart
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_pc", PC, 0);
        check("reset_memwrite", MemWriteM, 0);
        check("reset_addr", {A1, A2, A3}, 0);
        check("reset_wdata", writeData, 0);
        RST = 1'b1;
        #1 check("release_pc", PC, 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            check($sformatf("pc_step%0d", k), PC, k);
        end

        vecs[0] = mk("fwd", prog4(i_imm(OP_ADD, 4'd1, 4'd0, 14'd5), i_imm(OP_ADD, 4'd2, 4'd1, 14'd3),
                     i_str(4'd2, 4'd0, 14'd16), NOP), 2'd0, 1'b0, '0, 19'd16, {3{18'd8}}, 0);
        vecs[1] = mk("loaduse", prog4(i_ldr(4'd3, 4'd0, 14'd100), i_reg(OP_ADD, 4'd4, 4'd3, 4'd3),
                     i_str(4'd4, 4'd0, 14'd0), NOP), 2'd0, 1'b1, {18'd9, 18'd8, 18'd7},
                     19'd0, {18'd18, 18'd16, 18'd14}, 1);
        for (int k = 0; k < 4; k++) begin
            logic [17:0] e;
            e = (k == 0) ? 18'd13 : (k == 1) ? 18'd23 : (k == 2) ? 18'd43 : 18'd262137;
            vecs[2 + k] = mk($sformatf("flt_k%0d", k),
                             prog4(i_imm(OP_ADD, 4'd1, 4'd0, 14'd10), i_imm(OP_ADD, 4'd2, 4'd0, 14'd3),
                                   i_reg(OP_FLT, 4'd5, 4'd1, 4'd2), i_str(4'd5, 4'd0, 14'd0)),
                             2'(k), 1'b0, '0, 19'd0, {3{e}}, 0);
        end
        vecs[6] = mk("add_wrap", prog4(i_imm(OP_SUB, 4'd1, 4'd0, 14'd1), i_imm(OP_ADD, 4'd2, 4'd1, 14'd1),
                     i_str(4'd2, 4'd1, 14'd1), NOP), 2'd0, 1'b0, '0, 19'h40000, '0, 0);
        vecs[7] = mk("addr_wrap", prog4(i_imm(OP_ADD, 4'd7, 4'd0, 14'h1234),
                     i_str(4'd7, 4'd0, 14'h3FFF), NOP, NOP), 2'd0, 1'b0, '0, 19'h7FFFF,
                     {3{18'h1234}}, 0);
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Load address wrap: base 0 plus imm14 of -1
        for (int j = 0; j < 256; j++) imem[j] = NOP;
        imem[0] = i_ldr(4'd6, 4'd0, 14'h3FFF);
        do_reset();
        repeat (3) @(negedge CLK);
        check("ldr_addr_wrap", {MemWriteM, A1, A2, A3}, {1'b0, {3{19'h7FFFF}}});

        // Asynchronous reset while a store is in Memory
        for (int j = 0; j < 256; j++) imem[j] = NOP;
        imem[0] = i_imm(OP_ADD, 4'd1, 4'd0, 14'd9);
        imem[1] = i_str(4'd1, 4'd0, 14'd3);
        do_reset();
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge CLK);
            if (MemWriteM) seen = 1'b1;
        end
        check("midreset_store_seen", seen, 1);
        if (seen) begin
            check("midreset_store_data", {A1, writeData}, {19'd3, {3{18'd9}}});
            RST = 1'b0;
            #1;
            check("midreset_outputs", {MemWriteM, PC, writeData, A1, A2, A3}, 0);
        end
        RST = 1'b1;
        @(negedge CLK);
        check("midreset_restart_pc", PC, 1);

        for (int i = 0; i < 4; i++) run_random(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
